// File: rtl/msg_stream_serializer.sv
// Queues extracted 256-bit messages in a small FIFO and replays each one as a
// 32-bit Avalon-ST packet (sop/eop/empty) under ready/valid flow control.
module msg_stream_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [255:0]               in_data,
  input  logic [31:0]                in_bytemask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic [1:0]                 out_empty,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [255:0]  data_mem [DEPTH];
  logic [5:0]    len_mem  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [0:0]    state;
  logic [2:0]    beat_idx;
  logic [255:0]  shreg;
  logic [5:0]    cur_len;

  logic [5:0]    in_len;
  logic          run;
  logic [255:0]  head_masked;
  logic          full;
  logic          fifo_empty;
  logic          accept;
  logic          last_beat;
  logic          push;
  logic          pop;
  logic          drop;

  // Message length is the run of ones from bit 31; anything after the first zero is ignored.
  always_comb begin
    in_len = '0;
    run    = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (run && in_bytemask[5'(31 - i)]) in_len = in_len + 6'd1;
      else                                run    = 1'b0;
    end
  end

  // Bytes beyond the message length are zeroed once, when the head is loaded.
  always_comb begin
    head_masked = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < 32'(len_mem[rd_ptr]))
        head_masked[8'(255 - 8*i) -: 8] = data_mem[rd_ptr][8'(255 - 8*i) -: 8];
    end
  end

  always_comb begin
    full       = (count == FULL_LEVEL);
    fifo_empty = (count == '0);
    accept     = (state == ST_SEND) && out_ready;
    last_beat  = ({3'b000, beat_idx} == ((cur_len - 6'd1) >> 2));
    pop        = !fifo_empty && ((state == ST_IDLE) || (accept && last_beat));
    push       = in_valid && in_bytemask[31] && (!full || pop);
    drop       = in_valid && !push;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data;
      len_mem[wr_ptr]  <= in_len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Loading the next head on the eop-accept edge keeps consecutive packets gap-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      beat_idx <= '0;
      shreg    <= '0;
      cur_len  <= '0;
    end else if (pop) begin
      state    <= ST_SEND;
      beat_idx <= '0;
      shreg    <= head_masked;
      cur_len  <= len_mem[rd_ptr];
    end else if (accept) begin
      if (last_beat) begin
        state <= ST_IDLE;
      end else begin
        shreg    <= {shreg[223:0], 32'h0};
        beat_idx <= beat_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
    end
  end

  always_comb begin
    out_valid         = (state == ST_SEND);
    out_data          = out_valid ? shreg[255:224] : '0;
    out_startofpacket = out_valid && (beat_idx == '0);
    out_endofpacket   = out_valid && last_beat;
    out_empty         = (out_valid && last_beat) ? (2'd0 - cur_len[1:0]) : '0;
    fifo_level        = count;
  end

endmodule
